stream_framer: RTL and testbench

//  Upstream framing stage for the window-add block. Takes a raw 8-bit valid/ready byte stream and cuts it

---
 rtl/stream_pkg.sv | 14 +
 rtl/stream_framer_if.sv | 26 ++
 rtl/axis_skid2.sv | 73 +++++++
 rtl/stream_framer.sv | 91 +++++++++
 tb/tb_stream_framer.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the framing stage and its skid buffer.
package stream_pkg;

    localparam int unsigned DW      = 8;
    localparam int unsigned LW      = 5;
    localparam int unsigned MAX_LEN = (1 << LW) - 1;

    typedef struct packed {
        logic          last;
        logic          nw;
        logic [DW-1:0] data;
    } beat_t;

endpackage

// File: rtl/stream_framer_if.sv
// Byte-stream handshake bundle around the framer: input stream plus tagged output stream.
interface stream_framer_if #(
    parameter int unsigned DW = stream_pkg::DW
);
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          m_nw;

    // master: the framer itself (drives the tagged output stream)
    modport master (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last, m_nw
    );

    // slave: the surrounding source/sink
    modport slave (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last, m_nw
    );
endinterface

// File: rtl/axis_skid2.sv
// Two-entry registered skid buffer; s_ready and m_valid are both flops, so no
// combinational path runs from m_ready to s_ready.
module axis_skid2
    import stream_pkg::*;
#(
    parameter type T = beat_t
) (
    input  logic clk,
    input  logic reset,
    input  T     s_beat,
    input  logic s_valid,
    output logic s_ready,
    output T     m_beat,
    output logic m_valid,
    input  logic m_ready
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

    occ_t occ;
    T     e1;
    logic in_fire;
    logic out_fire;

    assign in_fire  = s_valid && s_ready;
    assign out_fire = m_valid && m_ready;

    // m_beat is the head entry; e1 only holds the beat that arrived while the head stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ     <= EMPTY;
            m_beat  <= '0;
            e1      <= '0;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
        end else begin
            case (occ)
                EMPTY: begin
                    if (in_fire) begin
                        m_beat  <= s_beat;
                        m_valid <= 1'b1;
                        occ     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_beat <= s_beat;
                    end else if (in_fire) begin
                        e1      <= s_beat;
                        s_ready <= 1'b0;
                        occ     <= FULL;
                    end else if (out_fire) begin
                        m_valid <= 1'b0;
                        occ     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        m_beat  <= e1;
                        s_ready <= 1'b1;
                        occ     <= ONE;
                    end
                end
                default: begin
                    occ     <= EMPTY;
                    m_valid <= 1'b0;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/stream_framer.sv
// Cuts a byte stream into cfg_len-beat frames and tags each beat with
// end-of-frame (m_last) and trailing-window (m_nw) flags.
module stream_framer
    import stream_pkg::*;
#(
    parameter int unsigned DW = stream_pkg::DW,
    parameter int unsigned LW = stream_pkg::LW
) (
    input  logic          clk,
    input  logic          reset,
    stream_framer_if.master io,
    input  logic [LW-1:0] cfg_len,
    input  logic [LW-1:0] cfg_k,
    output logic [7:0]    frm_cnt,
    output logic          err_short
);

    typedef struct packed {
        logic          last;
        logic          nw;
        logic [DW-1:0] data;
    } frame_beat_t;

    logic [LW-1:0] idx;
    logic [LW-1:0] len_q;
    logic [LW-1:0] k_q;
    logic [LW-1:0] cur_len;
    logic [LW-1:0] cur_k;
    logic [LW-1:0] len_m1;
    logic [LW:0]   thr;
    logic          tag_nw;
    logic          tag_last;
    logic          short_end;
    logic          in_fire;
    frame_beat_t   in_beat;
    frame_beat_t   out_beat;

    assign in_fire = io.s_valid && io.s_ready;

    // On the first beat of a frame the live config is used, since that is the value being latched
    always_comb begin
        cur_len   = (idx == '0) ? ((cfg_len == '0) ? LW'(1) : cfg_len) : len_q;
        cur_k     = (idx == '0) ? cfg_k : k_q;
        len_m1    = cur_len - 1'b1;
        thr       = (cur_k >= cur_len) ? '0 : ({1'b0, cur_len} - {1'b0, cur_k});
        tag_nw    = ({1'b0, idx} >= thr);
        tag_last  = (idx == len_m1) || io.s_last;
        short_end = io.s_last && (idx != len_m1);
        in_beat   = '{last: tag_last, nw: tag_nw, data: io.s_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            len_q     <= '0;
            k_q       <= '0;
            frm_cnt   <= '0;
            err_short <= 1'b0;
        end else if (in_fire) begin
            if (idx == '0) begin
                len_q <= cur_len;
                k_q   <= cur_k;
            end
            if (tag_last) begin
                idx     <= '0;
                frm_cnt <= frm_cnt + 1'b1;
            end else begin
                idx <= idx + 1'b1;
            end
            if (short_end) begin
                err_short <= 1'b1;
            end
        end
    end

    axis_skid2 #(.T(frame_beat_t)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .s_beat  (in_beat),
        .s_valid (io.s_valid),
        .s_ready (io.s_ready),
        .m_beat  (out_beat),
        .m_valid (io.m_valid),
        .m_ready (io.m_ready)
    );

    assign io.m_data = out_beat.data;
    assign io.m_last = out_beat.last;
    assign io.m_nw   = out_beat.nw;

endmodule

// File: tb/tb_stream_framer.sv
// Self-checking bench for stream_framer: directed vector tables plus randomized traffic
// scored against a frame-level reference model.
module tb_stream_framer;
    import stream_pkg::*;

    localparam int unsigned TLW = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [TLW-1:0] cfg_len;
    logic [TLW-1:0] cfg_k;
    logic [7:0]     frm_cnt;
    logic           err_short;

    stream_framer_if bus ();

    stream_framer #(.DW(8), .LW(TLW)) dut (
        .clk       (clk),
        .reset     (reset),
        .io        (bus),
        .cfg_len   (cfg_len),
        .cfg_k     (cfg_k),
        .frm_cnt   (frm_cnt),
        .err_short (err_short)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       nw;
        int         cyc;
    } obeat_t;

    obeat_t outq[$];
    obeat_t expq[$];
    obeat_t sb_e;
    obeat_t sb_o;

    // reference model state: position inside the current frame and the frame's latched config
    int m_pos = 0;
    int m_len = 1;
    int m_k   = 0;
    int m_frm = 0;
    int m_err = 0;

    bit         stall_prev = 1'b0;
    logic [7:0] held_d;
    logic       held_l;
    logic       held_n;

    task automatic model_accept();
        int thr;
        obeat_t e;
        if (m_pos == 0) begin
            m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
            m_k   = int'(cfg_k);
        end
        thr = m_len - m_k;
        if (thr < 0) thr = 0;
        e.data = bus.s_data;
        e.nw   = (m_pos >= thr);
        e.last = (m_pos == m_len - 1) || bus.s_last;
        e.cyc  = 0;
        if (bus.s_last && m_pos != m_len - 1) m_err = 1;
        expq.push_back(e);
        if (e.last) begin
            m_pos = 0;
            m_frm = (m_frm + 1) % 256;
        end else begin
            m_pos++;
        end
    endtask

    // monitor/scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            m_pos      = 0;
            m_frm      = 0;
            m_err      = 0;
            stall_prev = 1'b0;
        end else begin
            chk("frm_cnt", int'(frm_cnt), m_frm);
            chk("err_short", int'(err_short), m_err);
            chk("s_ready_occ", int'(bus.s_ready), int'(expq.size() <= 1));
            chk("m_valid_occ", int'(bus.m_valid), int'(expq.size() > 0));
            if (stall_prev) begin
                chk("hold_valid", int'(bus.m_valid), 1);
                chk("hold_data", int'(bus.m_data), int'(held_d));
                chk("hold_last", int'(bus.m_last), int'(held_l));
                chk("hold_nw", int'(bus.m_nw), int'(held_n));
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            held_d     = bus.m_data;
            held_l     = bus.m_last;
            held_n     = bus.m_nw;
            if (bus.m_valid && bus.m_ready) begin
                sb_o.data = bus.m_data;
                sb_o.last = bus.m_last;
                sb_o.nw   = bus.m_nw;
                sb_o.cyc  = cyc;
                outq.push_back(sb_o);
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got data %0d with nothing pending, required no beat", bus.m_data);
                end else begin
                    sb_e = expq.pop_front();
                    chk("sb_data", int'(bus.m_data), int'(sb_e.data));
                    chk("sb_last", int'(bus.m_last), int'(sb_e.last));
                    chk("sb_nw", int'(bus.m_nw), int'(sb_e.nw));
                end
            end
            if (bus.s_valid && bus.s_ready) model_accept();
        end
    end

    // downstream ready pattern: 0 always, 1 toggles 1,0,0,1, 2 random, 3 held low
    int rdy_mode = 0;
    int rdy_ph   = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.m_ready = 1'b1;
            1: begin
                bus.m_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
                rdy_ph++;
            end
            2: bus.m_ready = 1'($urandom_range(0, 1));
            default: bus.m_ready = 1'b0;
        endcase
    end

    task automatic send(input logic [7:0] d, input logic sl);
        bit ok;
        int n = 0;
        bus.s_data  = d;
        bus.s_last  = sl;
        bus.s_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: s_ready low for %0d cycles, required high within 100", n);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || bus.m_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", expq.size());
        end
    endtask

    typedef struct {
        logic [TLW-1:0] len;
        logic [TLW-1:0] k;
        logic [7:0]     data;
        logic           sl;
        logic           exp_nw;
        logic           exp_last;
    } vec_t;

    vec_t tab[$];

    task automatic add(input int len, input int k, input int d, input int sl, input int nw, input int l);
        vec_t v;
        v.len      = TLW'(len);
        v.k        = TLW'(k);
        v.data     = 8'(d);
        v.sl       = 1'(sl);
        v.exp_nw   = 1'(nw);
        v.exp_last = 1'(l);
        tab.push_back(v);
    endtask

    task automatic run_table(input string tag);
        outq.delete();
        foreach (tab[i]) begin
            cfg_len = tab[i].len;
            cfg_k   = tab[i].k;
            send(tab[i].data, tab[i].sl);
        end
        drain();
        chk({tag, "_count"}, outq.size(), tab.size());
        for (int i = 0; i < tab.size() && i < outq.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), int'(outq[i].data), int'(tab[i].data));
            chk($sformatf("%s_nw%0d", tag, i), int'(outq[i].nw), int'(tab[i].exp_nw));
            chk($sformatf("%s_last%0d", tag, i), int'(outq[i].last), int'(tab[i].exp_last));
        end
        tab.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sent[$];
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = '0;
        cfg_len     = 8;
        cfg_k       = 3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", int'(bus.m_valid), 0);
        chk("rst_m_data", int'(bus.m_data), 0);
        chk("rst_m_last", int'(bus.m_last), 0);
        chk("rst_m_nw", int'(bus.m_nw), 0);
        chk("rst_frm_cnt", int'(frm_cnt), 0);
        chk("rst_err_short", int'(err_short), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", int'(bus.s_ready), 1);
        @(posedge clk);
        #1;

        // two 8-beat frames, window of 3, full throughput
        for (int i = 1; i <= 16; i++) add(8, 3, i, 0, ((i - 1) % 8) >= 5, ((i - 1) % 8) == 7);
        run_table("t1");
        if (outq.size() == 16) chk("t1_no_gap", outq[15].cyc - outq[0].cyc, 15);
        chk("t1_frm_cnt", int'(frm_cnt), 2);
        chk("t1_err_short", int'(err_short), 0);

        // back-pressure with ready pattern 1,0,0,1
        rdy_mode = 1;
        rdy_ph   = 0;
        cfg_len  = 5;
        cfg_k    = 2;
        outq.delete();
        for (int i = 0; i < 20; i++) begin
            sent.push_back(8'($urandom_range(0, 255)));
            send(sent[i], 1'b0);
        end
        drain();
        rdy_mode = 0;
        chk("t2_count", outq.size(), 20);
        for (int i = 0; i < 20 && i < outq.size(); i++) chk($sformatf("t2_order%0d", i), int'(outq[i].data), int'(sent[i]));
        chk("t2_frm_cnt", int'(frm_cnt), 6);

        // early end on beat 3 of a 6-beat frame, then a normal frame
        add(6, 2, 1, 0, 0, 0);
        add(6, 2, 2, 0, 0, 0);
        add(6, 2, 3, 1, 0, 1);
        for (int j = 0; j < 6; j++) add(6, 2, 4 + j, 0, j >= 4, j == 5);
        run_table("t3");
        chk("t3_err_short", int'(err_short), 1);
        chk("t3_frm_cnt", int'(frm_cnt), 8);

        // k=0 frame with k changed mid-frame, then k=7 frame with k changed mid-frame
        add(4, 0, 1, 0, 0, 0);
        add(4, 7, 2, 0, 0, 0);
        add(4, 7, 3, 0, 0, 0);
        add(4, 7, 4, 0, 0, 1);
        add(4, 7, 5, 0, 1, 0);
        add(4, 7, 6, 0, 1, 0);
        add(4, 0, 7, 0, 1, 0);
        add(4, 0, 8, 0, 1, 1);
        run_table("t4");
        chk("t4_frm_cnt", int'(frm_cnt), 10);

        // len=0 behaves as len=1
        for (int i = 0; i < 3; i++) add(0, 1, 20 + i, 0, 1, 1);
        run_table("t5");
        chk("t5_frm_cnt", int'(frm_cnt), 13);

        // a normal end with s_last on the final beat does not raise err_short
        // (err_short is already sticky here, so this is checked again after reset below)

        // reset in the middle of a frame while beats are buffered
        cfg_len = 8;
        cfg_k   = 3;
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_m_valid", int'(bus.m_valid), 0);
        chk("t6_m_data", int'(bus.m_data), 0);
        chk("t6_m_last", int'(bus.m_last), 0);
        chk("t6_frm_cnt", int'(frm_cnt), 0);
        chk("t6_err_short", int'(err_short), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int j = 0; j < 7; j++) add(8, 3, 11 + j, 0, j >= 5, 0);
        add(8, 3, 18, 1, 1, 1);
        run_table("t6");
        chk("t6_frm_after", int'(frm_cnt), 1);
        chk("t6_err_after", int'(err_short), 0);

        // randomized traffic against the reference model
        rdy_mode = 2;
        outq.delete();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) cfg_len = TLW'($urandom_range(0, MAX_LEN));
            if ($urandom_range(0, 3) == 0) cfg_k = TLW'($urandom_range(0, MAX_LEN));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0));
        end
        drain();
        rdy_mode = 0;
        chk("t7_count", outq.size(), 400);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
